// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control FSM with retired-instruction counter
// Optional MEM stall on mem_ready: define MC_CTRL_STALL_EN.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
`ifdef MC_CTRL_STALL_EN
  input  logic        mem_ready,
`endif
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_sel,
  output logic [1:0]  reg_dst,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_ILL
  } cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, dec_cls;
  logic [31:0] retired_q;
  logic        retire;
  logic        mem_done;
  logic        pc_write_c, ir_write_c, reg_write_c, mem_write_c, illegal_c;
  logic [1:0]  pc_src_c, wb_sel_c, reg_dst_c, alu_op_c;
  logic        alu_src_c;

`ifdef MC_CTRL_STALL_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  // Only consulted in DECODE; op/func are don't-care everywhere else.
  always_comb begin
    dec_cls = C_ILL;
    case (op)
      6'h00: begin
        case (func)
          6'h21:   dec_cls = C_ADDU;
          6'h23:   dec_cls = C_SUBU;
          6'h08:   dec_cls = C_JR;
          6'h00:   dec_cls = C_NOP;
          default: dec_cls = C_ILL;
        endcase
      end
      6'h0d:   dec_cls = C_ORI;
      6'h0f:   dec_cls = C_LUI;
      6'h23:   dec_cls = C_LW;
      6'h2b:   dec_cls = C_SW;
      6'h04:   dec_cls = C_BEQ;
      6'h03:   dec_cls = C_JAL;
      default: dec_cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NOP;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        cls_q <= dec_cls;
      if (retire)
        retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    retire      = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    illegal_c   = 1'b0;
    pc_src_c    = 2'd0;
    wb_sel_c    = 2'd0;
    reg_dst_c   = 2'd0;
    alu_op_c    = 2'd0;
    alu_src_c   = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls_q)
        C_ADDU:     begin alu_op_c = 2'd0; alu_src_c = 1'b0; end
        C_SUBU:     begin alu_op_c = 2'd1; alu_src_c = 1'b0; end
        C_ORI:      begin alu_op_c = 2'd2; alu_src_c = 1'b1; end
        C_LUI:      begin alu_op_c = 2'd3; alu_src_c = 1'b1; end
        C_LW, C_SW: begin alu_op_c = 2'd0; alu_src_c = 1'b1; end
        C_BEQ:      begin alu_op_c = 2'd1; alu_src_c = 1'b0; end
        default:    begin alu_op_c = 2'd0; alu_src_c = 1'b0; end
      endcase
    end

    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        case (dec_cls)
          C_NOP:   begin retire = 1'b1; state_d = S_FETCH; end
          C_ILL:   begin illegal_c = 1'b1; state_d = S_FETCH; end
          C_JAL:   state_d = S_WB;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ: begin
            pc_write_c = zero;
            pc_src_c   = zero ? 2'd1 : 2'd0;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          C_JR: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'd3;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          C_LW, C_SW:                   state_d = S_MEM;
          C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
          default:                      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_write_c = (cls_q == C_SW);
        if (!mem_done)
          state_d = S_MEM;
        else if (cls_q == C_LW)
          state_d = S_WB;
        else begin
          retire  = (cls_q == C_SW);
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        case (cls_q)
          C_ADDU, C_SUBU: begin reg_write_c = 1'b1; reg_dst_c = 2'd1; retire = 1'b1; end
          C_ORI, C_LUI:   begin reg_write_c = 1'b1; retire = 1'b1; end
          C_LW:           begin reg_write_c = 1'b1; wb_sel_c = 2'd1; retire = 1'b1; end
          C_JAL: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 2'd2;
            wb_sel_c    = 2'd2;
            pc_write_c  = 1'b1;
            pc_src_c    = 2'd2;
            retire      = 1'b1;
          end
          default: reg_write_c = 1'b0;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are masked during reset so an aborted instruction never commits.
  assign pc_write  = pc_write_c  & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign illegal   = illegal_c   & ~reset;
  assign pc_src    = pc_src_c;
  assign wb_sel    = wb_sel_c;
  assign reg_dst   = reg_dst_c;
  assign alu_op    = alu_op_c;
  assign alu_src   = alu_src_c;
  assign state     = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl (table vectors, directed corners, random vs model)
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, func;
  logic        zero;
`ifdef MC_CTRL_STALL_EN
  logic        mem_ready;
`endif
  logic        pc_write, ir_write, reg_write, mem_write, alu_src, illegal;
  logic [1:0]  pc_src, wb_sel, reg_dst, alu_op;
  logic [2:0]  state;
  logic [31:0] retired;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
`ifdef MC_CTRL_STALL_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
    .pc_src(pc_src), .wb_sel(wb_sel), .reg_dst(reg_dst), .alu_op(alu_op), .alu_src(alu_src),
    .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_write, ir_write, reg_write, mem_write;
    logic [1:0] pc_src, wb_sel, reg_dst, alu_op;
    logic       alu_src, illegal;
  } outv_t;

  outv_t act;
  assign act = {state, pc_write, ir_write, reg_write, mem_write,
                pc_src, wb_sel, reg_dst, alu_op, alu_src, illegal};

  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4, K_LUI = 5,
                 K_LW = 6, K_SW = 7, K_BEQ = 8, K_JAL = 9, K_ILL = 10;

  int          checks = 0;
  int          errors = 0;
  int unsigned model_retired = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f == 6'h21) return K_ADDU;
      if (f == 6'h23) return K_SUBU;
      if (f == 6'h08) return K_JR;
      if (f == 6'h00) return K_NOP;
      return K_ILL;
    end
    if (o == 6'h0d) return K_ORI;
    if (o == 6'h0f) return K_LUI;
    if (o == 6'h23) return K_LW;
    if (o == 6'h2b) return K_SW;
    if (o == 6'h04) return K_BEQ;
    if (o == 6'h03) return K_JAL;
    return K_ILL;
  endfunction

  // Expected outputs straight from the per-state/per-class rules.
  function automatic outv_t exp_out(input int k, input logic [2:0] st, input logic z);
    outv_t o;
    o = '0;
    o.st = st;
    if (st >= 3'd2) begin
      if (k == K_SUBU || k == K_BEQ) o.alu_op = 2'd1;
      if (k == K_ORI) o.alu_op = 2'd2;
      if (k == K_LUI) o.alu_op = 2'd3;
      o.alu_src = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
    end
    case (st)
      3'd0: begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
      3'd1: o.illegal = (k == K_ILL);
      3'd2: begin
        if (k == K_BEQ && z) begin o.pc_write = 1'b1; o.pc_src = 2'd1; end
        if (k == K_JR)       begin o.pc_write = 1'b1; o.pc_src = 2'd3; end
      end
      3'd3: o.mem_write = (k == K_SW);
      3'd4: begin
        o.reg_write = 1'b1;
        if (k == K_ADDU || k == K_SUBU) o.reg_dst = 2'd1;
        if (k == K_LW) o.wb_sel = 2'd1;
        if (k == K_JAL) begin
          o.reg_dst = 2'd2; o.wb_sel = 2'd2; o.pc_write = 1'b1; o.pc_src = 2'd2;
        end
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Runs one instruction from FETCH, checking every cycle; stall = extra MEM cycles.
  task automatic run_instr(input logic [5:0] op_i, input logic [5:0] func_i, input logic zero_i,
                           input int stall, input bit scramble);
    logic [2:0] q[$];
    int k;
    int mem_idx;
    k = classify(op_i, func_i);
    q.push_back(3'd0);
    q.push_back(3'd1);
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI: begin q.push_back(3'd2); q.push_back(3'd4); end
      K_LW: begin
        q.push_back(3'd2);
        for (int s = 0; s <= stall; s++) q.push_back(3'd3);
        q.push_back(3'd4);
      end
      K_SW: begin
        q.push_back(3'd2);
        for (int s = 0; s <= stall; s++) q.push_back(3'd3);
      end
      K_BEQ, K_JR: q.push_back(3'd2);
      K_JAL:       q.push_back(3'd4);
      default:     ;
    endcase
    mem_idx = 0;
    foreach (q[i]) begin
      op   = (i <= 1 || !scramble) ? op_i   : 6'($urandom);
      func = (i <= 1 || !scramble) ? func_i : 6'($urandom);
      zero = (q[i] == 3'd2 || !scramble) ? zero_i : 1'($urandom);
`ifdef MC_CTRL_STALL_EN
      if (q[i] == 3'd3) begin
        mem_ready = (mem_idx < stall) ? 1'b0 : 1'b1;
        mem_idx++;
      end else begin
        mem_ready = scramble ? 1'($urandom) : 1'b1;
      end
`endif
      #1;
      chk($sformatf("outputs op=%0h func=%0h cyc=%0d", op_i, func_i, i), 32'(act), 32'(exp_out(k, q[i], zero)));
      @(posedge clk); #1;
    end
    if (k != K_ILL) model_retired++;
    chk("back_to_fetch", 32'(state), 32'd0);
    chk("retired", retired, model_retired);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         cycles;
    int         ret_inc;
  } vec_t;

  vec_t vecs[14];
  logic [5:0] legal_ops[10];
  logic [5:0] legal_funcs[10];

  initial begin
    vecs[0]  = '{6'h00, 6'h21, 1'b0, 4, 1};
    vecs[1]  = '{6'h00, 6'h23, 1'b0, 4, 1};
    vecs[2]  = '{6'h00, 6'h08, 1'b0, 3, 1};
    vecs[3]  = '{6'h00, 6'h00, 1'b0, 2, 1};
    vecs[4]  = '{6'h0d, 6'h15, 1'b0, 4, 1};
    vecs[5]  = '{6'h0f, 6'h00, 1'b1, 4, 1};
    vecs[6]  = '{6'h23, 6'h00, 1'b0, 5, 1};
    vecs[7]  = '{6'h2b, 6'h00, 1'b0, 4, 1};
    vecs[8]  = '{6'h04, 6'h00, 1'b1, 3, 1};
    vecs[9]  = '{6'h04, 6'h00, 1'b0, 3, 1};
    vecs[10] = '{6'h03, 6'h00, 1'b0, 3, 1};
    vecs[11] = '{6'h3f, 6'h00, 1'b0, 2, 0};
    vecs[12] = '{6'h00, 6'h3f, 1'b0, 2, 0};
    vecs[13] = '{6'h01, 6'h21, 1'b0, 2, 0};
    legal_ops   = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h03};
    legal_funcs = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    reset = 1'b1; op = 6'h00; func = 6'h00; zero = 1'b0;
`ifdef MC_CTRL_STALL_EN
    mem_ready = 1'b1;
`endif
    @(posedge clk); #1;
    chk("reset_enables", 32'({pc_write, ir_write, reg_write, mem_write, illegal}), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("reset_retired", retired, 32'd0);

    // addu: F-D-E-W, reg_write/reg_dst=1 only in WB
    run_instr(6'h00, 6'h21, 1'b0, 0, 1'b0);
    // lw then sw, beq taken / not taken, illegal
    run_instr(6'h23, 6'h00, 1'b0, 0, 1'b0);
    run_instr(6'h2b, 6'h00, 1'b0, 0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1, 0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 1'b0);
    run_instr(6'h3f, 6'h00, 1'b0, 0, 1'b0);

    foreach (vecs[v]) begin
      int cyc;
      int unsigned r0;
      r0 = retired;
      op = vecs[v].op; func = vecs[v].func; zero = vecs[v].zero;
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (state != 3'd0 && cyc < 20);
      chk($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vecs[v].cycles));
      chk($sformatf("vec%0d_retire", v), retired - r0, 32'(vecs[v].ret_inc));
      model_retired = model_retired + 32'(vecs[v].ret_inc);
    end

    // Reset during MEM of sw aborts the store.
    op = 6'h2b; func = 6'h00; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_mem", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_enables", 32'({pc_write, ir_write, reg_write, illegal}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_retired", retired, 32'd0);
    model_retired = 0;

`ifdef MC_CTRL_STALL_EN
    run_instr(6'h2b, 6'h00, 1'b0, 3, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0, 2, 1'b0);
`endif

    for (int n = 0; n < 300; n++) begin
      int pick;
      logic [5:0] o, f;
      int st;
      pick = int'($urandom_range(0, 12));
      if (pick < 10) begin
        o = legal_ops[pick];
        f = (o == 6'h00) ? legal_funcs[pick] : 6'($urandom);
      end else begin
        o = 6'($urandom); f = 6'($urandom);
      end
      st = 0;
`ifdef MC_CTRL_STALL_EN
      st = int'($urandom_range(0, 3));
`endif
      run_instr(o, f, 1'($urandom), st, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
